// File: rtl/p66b_blocklock_pkg.sv
// ----------------------------------------------------------------------------
// p66b_blocklock_pkg : shared constants and state type for the 66b block lock.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package p66b_blocklock_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // 125 us at a 156.25 MHz word clock
  localparam int BER_WINDOW_156M = 19531;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } blk_state_t;

  function automatic logic sync_ok(input logic [1:0] sync);
    return (sync == SYNC_DATA) || (sync == SYNC_CTRL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/p66b_bermon.sv
// ----------------------------------------------------------------------------
// p66b_bermon : free-running BER window that flags too many bad sync headers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module p66b_bermon
  import p66b_blocklock_pkg::*;
#(
  parameter int BER_WINDOW = BER_WINDOW_156M,
  parameter int BER_LIMIT  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic bad,
  output logic hi_ber,
  output logic hi_ber_next
);

  localparam int CW = $clog2(BER_WINDOW + 1);
  localparam int BW = $clog2(BER_LIMIT + 1);
  localparam logic [CW-1:0] C_WIN_LAST = CW'(BER_WINDOW - 1);
  localparam logic [BW-1:0] C_LIMIT    = BW'(BER_LIMIT);

  logic [CW-1:0] r_clk_cnt;
  logic [BW-1:0] r_ber_cnt;
  logic [BW-1:0] w_ber_next;
  logic          r_hi_ber;
  logic          w_win_end;
  logic          w_hit;

  assign w_win_end = (r_clk_cnt == C_WIN_LAST);
  assign w_hit     = locked && bad;

  // A hit in the window-end cycle opens the new window with a count of one.
  always_comb begin
    w_ber_next  = r_ber_cnt;
    hi_ber_next = r_hi_ber;
    if (!locked) begin
      w_ber_next = '0;
    end else if (w_win_end) begin
      w_ber_next = w_hit ? BW'(1) : '0;
    end else if (w_hit && (r_ber_cnt != C_LIMIT)) begin
      w_ber_next = r_ber_cnt + BW'(1);
    end
    if (w_win_end && (r_ber_cnt < C_LIMIT)) begin
      hi_ber_next = 1'b0;
    end
    if (w_hit && (w_ber_next == C_LIMIT)) begin
      hi_ber_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else begin
      r_clk_cnt <= w_win_end ? '0 : r_clk_cnt + CW'(1);
      r_ber_cnt <= w_ber_next;
      r_hi_ber  <= hi_ber_next;
    end
  end

  assign hi_ber = r_hi_ber;

endmodule

`default_nettype wire

// File: rtl/p66b_blocklock.sv
// ----------------------------------------------------------------------------
// p66b_blocklock : 64b/66b block-lock FSM with gearbox slip and link gating.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module p66b_blocklock
  import p66b_blocklock_pkg::*;
#(
  parameter int LOCK_COUNT  = 64,
  parameter int TEST_WINDOW = 64,
  parameter int MAX_INVALID = 16,
  parameter int SLIP_WAIT   = 4,
  parameter int BER_WINDOW  = BER_WINDOW_156M,
  parameter int BER_LIMIT   = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [1:0] i_sync,
  output logic       o_slip,
  output logic       o_locked,
  output logic       o_hi_ber,
  output logic       o_link_up
);

  localparam int SHW = $clog2(LOCK_COUNT + 1);
  localparam int WNW = $clog2(TEST_WINDOW + 1);
  localparam int IVW = $clog2(MAX_INVALID + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);
  localparam logic [SHW-1:0] C_SH_LAST   = SHW'(LOCK_COUNT - 1);
  localparam logic [WNW-1:0] C_WIN_LAST  = WNW'(TEST_WINDOW - 1);
  localparam logic [IVW-1:0] C_INV_LAST  = IVW'(MAX_INVALID - 1);
  localparam logic [WTW-1:0] C_WAIT_LAST = WTW'(SLIP_WAIT - 1);

  blk_state_t     r_state;
  logic [SHW-1:0] r_sh_cnt;
  logic [WNW-1:0] r_win_cnt;
  logic [IVW-1:0] r_inv_cnt;
  logic [WTW-1:0] r_wait_cnt;
  logic           r_primed;
  logic           r_slip;
  logic           r_locked;
  logic           r_link_up;
  logic           w_good;
  logic           w_bad;
  logic           w_hi_ber_next;

  assign w_good = i_valid && sync_ok(i_sync);
  assign w_bad  = i_valid && !sync_ok(i_sync);

  p66b_bermon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_LIMIT  (BER_LIMIT)
  ) u_bermon (
    .clk         (i_clk),
    .rst         (i_reset),
    .locked      (r_locked),
    .bad         (w_bad),
    .hi_ber      (o_hi_ber),
    .hi_ber_next (w_hi_ber_next)
  );

  // SLIP is entered with r_slip already high from HUNT, or low after a lock
  // loss; the latter spends one extra cycle so the pulse lands a cycle later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_HUNT;
      r_sh_cnt   <= '0;
      r_win_cnt  <= '0;
      r_inv_cnt  <= '0;
      r_wait_cnt <= '0;
      r_primed   <= 1'b0;
      r_slip     <= 1'b0;
      r_locked   <= 1'b0;
      r_link_up  <= 1'b0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          r_link_up <= 1'b0;
          if (w_bad) begin
            r_state <= ST_SLIP;
            r_slip  <= 1'b1;
          end else if (w_good) begin
            if (r_sh_cnt == C_SH_LAST) begin
              r_state   <= ST_LOCKED;
              r_locked  <= 1'b1;
              r_sh_cnt  <= '0;
              r_win_cnt <= '0;
              r_inv_cnt <= '0;
              r_primed  <= 1'b0;
            end else begin
              r_sh_cnt <= r_sh_cnt + SHW'(1);
            end
          end
        end
        ST_SLIP: begin
          r_sh_cnt   <= '0;
          r_wait_cnt <= '0;
          r_link_up  <= 1'b0;
          if (r_slip) begin
            r_slip  <= 1'b0;
            r_state <= ST_WAIT;
          end else begin
            r_slip <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_valid) begin
            if (r_wait_cnt == C_WAIT_LAST) begin
              r_wait_cnt <= '0;
              r_state    <= ST_HUNT;
            end else begin
              r_wait_cnt <= r_wait_cnt + WTW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (i_valid) begin
            r_primed <= 1'b1;
            if (w_bad && (r_inv_cnt == C_INV_LAST)) begin
              r_state   <= ST_SLIP;
              r_locked  <= 1'b0;
              r_primed  <= 1'b0;
              r_link_up <= 1'b0;
              r_win_cnt <= '0;
              r_inv_cnt <= '0;
            end else begin
              r_link_up <= !w_hi_ber_next;
              if (r_win_cnt == C_WIN_LAST) begin
                r_win_cnt <= '0;
                r_inv_cnt <= '0;
              end else begin
                r_win_cnt <= r_win_cnt + WNW'(1);
                if (w_bad) begin
                  r_inv_cnt <= r_inv_cnt + IVW'(1);
                end
              end
            end
          end else begin
            r_link_up <= r_primed && !w_hi_ber_next;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign o_slip    = r_slip;
  assign o_locked  = r_locked;
  assign o_link_up = r_link_up;

endmodule

`default_nettype wire
